// File: rtl/regfile_pkg.sv
// Shared types and sizes for the 8x32 register file and its building blocks.
package regfile_pkg;

    parameter int XLEN  = 32;
    parameter int NREGS = 8;

    typedef logic [XLEN-1:0] word_t;
    typedef logic [2:0]      reg_addr_t;

endpackage

// File: rtl/mux4to1_b32.sv
// 4:1 32-bit read-port selector used by the register file; purely combinational.
module mux4to1_b32
    import regfile_pkg::*;
(
    input  logic  S1,
    input  logic  S0,
    input  word_t D3,
    input  word_t D2,
    input  word_t D1,
    input  word_t D0,
    output word_t Y
);

    always_comb begin
        // An unknown select falls to the default so X propagates in simulation
        case ({S1, S0})
            2'b00:   Y = D0;
            2'b01:   Y = D1;
            2'b10:   Y = D2;
            2'b11:   Y = D3;
            default: Y = 'x;
        endcase
    end

endmodule

// File: rtl/enabled_register.sv
// WIDTH-bit register with write enable and synchronous active-low reset;
// one instance per architectural register.
module enabled_register
    import regfile_pkg::*;
#(
    parameter int                 WIDTH     = XLEN,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    output logic [WIDTH-1:0] Q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Ternary rather than if so an X on EN yields X on Q instead of a silent hold
    always_comb begin
        q_d = EN ? D : q_q;
    end

    always_ff @(posedge CLK) begin
        if (!RESET_N) q_q <= RESET_VAL;
        else          q_q <= q_d;
    end

    assign Q = q_q;

endmodule

// File: tb/tb_enabled_register.sv
// Directed bench for enabled_register and mux4to1_b32, including a two-register mini file.
module tb_enabled_register;
    import regfile_pkg::*;

    logic  clk = 1'b0;
    always #5 clk = ~clk;

    logic  rst_n, en, en0, en1;
    word_t d, q, q0, q1;
    logic  ms1, ms0, is1, is0;
    word_t md1, md0, my, iy;

    int errors = 0;
    int checks = 0;

    enabled_register #(.WIDTH(XLEN), .RESET_VAL('0)) dut (
        .CLK(clk), .RESET_N(rst_n), .D(d), .EN(en), .Q(q)
    );

    enabled_register r0 (.CLK(clk), .RESET_N(rst_n), .D(d), .EN(en0), .Q(q0));
    enabled_register r1 (.CLK(clk), .RESET_N(rst_n), .D(d), .EN(en1), .Q(q1));

    mux4to1_b32 mux_sweep (
        .S1(ms1), .S0(ms0), .D3(32'h2A), .D2(32'h3F), .D1(md1), .D0(md0), .Y(my)
    );
    mux4to1_b32 mux_int (
        .S1(is1), .S0(is0), .D3(32'h2A), .D2(32'h3F), .D1(q1), .D0(q0), .Y(iy)
    );

    typedef struct {
        logic  rst_n;
        logic  en;
        word_t d;
        word_t exp;
    } vec_t;

    typedef struct {
        logic [1:0] sel;
        word_t      exp;
    } mvec_t;

    vec_t  vecs[$];
    mvec_t mvecs[$];

    task automatic check(input string name, input word_t act, input word_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; en0 = 1'b0; en1 = 1'b0; d = '0;
        ms1 = 1'b0; ms0 = 1'b0; is1 = 1'b0; is0 = 1'b0;
        md1 = 32'h11111111; md0 = 32'h00000000;

        // reset held with EN=1, then released
        vecs.push_back('{1'b0, 1'b1, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b0, 1'b1, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'hDEADBEEF, 32'h0});
        // load then hold for 5 edges
        vecs.push_back('{1'b1, 1'b1, 32'h12345678, 32'h12345678});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b1, 1'b0, 32'hFFFFFFFF, 32'h12345678});
        // back-to-back writes
        vecs.push_back('{1'b1, 1'b1, 32'h1, 32'h1});
        vecs.push_back('{1'b1, 1'b1, 32'h2, 32'h2});
        vecs.push_back('{1'b1, 1'b1, 32'h3, 32'h3});
        // reset priority mid-operation
        vecs.push_back('{1'b1, 1'b1, 32'hA5A5A5A5, 32'hA5A5A5A5});
        vecs.push_back('{1'b0, 1'b1, 32'h5A5A5A5A, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h5A5A5A5A, 32'h0});
        vecs.push_back('{1'b1, 1'b0, 32'h5A5A5A5A, 32'h0});

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; en = vecs[i].en; d = vecs[i].d;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), q, vecs[i].exp);
        end

        // load a known value, then D changes with EN low: no comb path to Q
        @(negedge clk);
        en = 1'b1; d = 32'hC0FFEE00;
        @(posedge clk);
        #1 check("load_c0ffee", q, 32'hC0FFEE00);
        @(negedge clk);
        en = 1'b0; d = 32'h13572468;
        #1 check("no_comb_path", q, 32'hC0FFEE00);

        // EN/D pulse between edges, withdrawn before the edge
        en = 1'b1; d = 32'h77777777;
        #2 en = 1'b0; d = 32'h0;
        @(posedge clk);
        #1 check("mid_cycle_glitch", q, 32'hC0FFEE00);

        // mux sweep
        mvecs.push_back('{2'b00, 32'h00000000});
        mvecs.push_back('{2'b01, 32'h11111111});
        mvecs.push_back('{2'b10, 32'h0000003F});
        mvecs.push_back('{2'b11, 32'h0000002A});
        mvecs.push_back('{2'b00, 32'h00000000});
        foreach (mvecs[i]) begin
            {ms1, ms0} = mvecs[i].sel;
            #1 check($sformatf("mux_sel%0d", i), my, mvecs[i].exp);
        end
        md0 = 32'hFEEDF00D;
        #1 check("mux_d0_follow", my, 32'hFEEDF00D);

        // mini-file integration
        @(negedge clk);
        d = 32'hCAFE; en0 = 1'b1;
        @(posedge clk);
        #1 {is1, is0} = 2'b00;
        #1 check("int_reg0", iy, 32'h0000CAFE);
        @(negedge clk);
        en0 = 1'b0; d = 32'hBEEF; en1 = 1'b1;
        @(posedge clk);
        #1 {is1, is0} = 2'b01;
        #1 check("int_reg1", iy, 32'h0000BEEF);
        {is1, is0} = 2'b00;
        #1 check("int_reg0_hold", iy, 32'h0000CAFE);
        {is1, is0} = 2'b10;
        #1 check("int_const3f", iy, 32'h0000003F);
        @(negedge clk);
        en1 = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
